// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master device bus arbiter: control pin
// bit positions, status bits and FSM state encodings.
package bus_arbiter_pkg;

    // Bit positions within mN_ctrl / dev_ctrl
    localparam int CTRL_READ  = 0;
    localparam int CTRL_WRITE = 1;

    // Bit positions within mN_stat
    localparam int STAT_DONE  = 0;
    localparam int STAT_ERR   = 1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // Build a completed-transfer status word
    function automatic logic [1:0] mk_stat(input logic err);
        logic [1:0] s;
        s            = 2'b00;
        s[STAT_DONE] = 1'b1;
        s[STAT_ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr2.sv
// Two-requester round-robin picker. When both masters request, the one
// that was not served last wins; a lone requester always wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Pick the grant index from the request vector and the last-served pointer
    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master device bus arbiter and handshake sequencer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_IDLE  | no transfer; arbitrate and capture the winner's request
//   ARB_ISSUE | wait for the previous device to release ACK, then drive pin
//   ARB_WAIT  | pin asserted, waiting for device ACK or timeout
//   ARB_DONE  | status held to the granted master until it drops its ctrl
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m0_ctrl,
    input  logic [WORD_WIDTH-1:0] m0_addr,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    output logic [WORD_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_stat,
    input  logic [1:0]            m1_ctrl,
    input  logic [WORD_WIDTH-1:0] m1_addr,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    output logic [WORD_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_stat,
    output logic [1:0]            dev_ctrl,
    input  logic                  dev_ack,
    output logic [WORD_WIDTH-1:0] addr,
    output logic [WORD_WIDTH-1:0] data_out,
    input  logic [WORD_WIDTH-1:0] data_in
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT);

    arb_state_t            state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic [1:0]            op_q, op_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] addr_d, data_out_d, m0_rdata_d, m1_rdata_d;
    logic [1:0]            dev_ctrl_d, m0_stat_d, m1_stat_d;

    logic [1:0] req;
    logic       rr_gnt;
    logic       rr_valid;
    logic [1:0] sel_ctrl;

    assign req      = {(m1_ctrl != 2'b00), (m0_ctrl != 2'b00)};
    assign sel_ctrl = gnt_q ? m1_ctrl : m0_ctrl;

    arb_rr2 u_rr (
        .req   (req),
        .last  (last_q),
        .gnt   (rr_gnt),
        .valid (rr_valid)
    );

    // State and all registered outputs; reset leaves master 1 as last served
    // so master 0 wins a simultaneous first request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= 1'b0;
            op_q     <= 2'b00;
            err_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            addr     <= '0;
            data_out <= '0;
            dev_ctrl <= 2'b00;
            m0_rdata <= '0;
            m1_rdata <= '0;
            m0_stat  <= 2'b00;
            m1_stat  <= 2'b00;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            err_q    <= err_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr     <= addr_d;
            data_out <= data_out_d;
            dev_ctrl <= dev_ctrl_d;
            m0_rdata <= m0_rdata_d;
            m1_rdata <= m1_rdata_d;
            m0_stat  <= m0_stat_d;
            m1_stat  <= m1_stat_d;
        end
    end

    // Next-state and next-output decode for the arbitration/handshake FSM
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        err_d      = err_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        addr_d     = addr;
        data_out_d = data_out;
        dev_ctrl_d = dev_ctrl;
        m0_rdata_d = m0_rdata;
        m1_rdata_d = m1_rdata;
        m0_stat_d  = m0_stat;
        m1_stat_d  = m1_stat;

        case (state_q)
            ARB_IDLE: begin
                if (rr_valid) begin
                    gnt_d      = rr_gnt;
                    addr_d     = rr_gnt ? m1_addr  : m0_addr;
                    data_out_d = rr_gnt ? m1_wdata : m0_wdata;
                    op_d       = rr_gnt ? m1_ctrl  : m0_ctrl;
                    cnt_d      = '0;
                    if (op_d == 2'b11) begin
                        // Status for an illegal op is raised from DONE itself,
                        // one cycle after entry.
                        err_d   = 1'b1;
                        state_d = ARB_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ARB_ISSUE;
                    end
                end
            end

            ARB_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_TC) begin
                    dev_ctrl_d = 2'b00;
                    err_d      = 1'b1;
                    state_d    = ARB_DONE;
                    if (gnt_q) m1_stat_d = mk_stat(1'b1);
                    else       m0_stat_d = mk_stat(1'b1);
                end else if (!dev_ack) begin
                    dev_ctrl_d = op_q;
                    state_d    = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dev_ack) begin
                    if (op_q[CTRL_READ]) begin
                        if (gnt_q) m1_rdata_d = data_in;
                        else       m0_rdata_d = data_in;
                    end
                    dev_ctrl_d = 2'b00;
                    err_d      = 1'b0;
                    state_d    = ARB_DONE;
                    if (gnt_q) m1_stat_d = mk_stat(1'b0);
                    else       m0_stat_d = mk_stat(1'b0);
                end else if (cnt_q == CNT_TC) begin
                    dev_ctrl_d = 2'b00;
                    err_d      = 1'b1;
                    state_d    = ARB_DONE;
                    if (gnt_q) m1_stat_d = mk_stat(1'b1);
                    else       m0_stat_d = mk_stat(1'b1);
                end
            end

            ARB_DONE: begin
                if (sel_ctrl == 2'b00) begin
                    m0_stat_d = 2'b00;
                    m1_stat_d = 2'b00;
                    last_d    = gnt_q;
                    state_d   = ARB_IDLE;
                end else begin
                    if (gnt_q) m1_stat_d = mk_stat(err_q);
                    else       m0_stat_d = mk_stat(err_q);
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single read, contention, fairness,
// stuck ACK, timeout, illegal op and reset mid-transfer.
module tb_bus_arbiter;

    localparam int W  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   m0_ctrl = 2'b00, m1_ctrl = 2'b00;
    logic [W-1:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic [1:0]   m0_stat, m1_stat, dev_ctrl;
    logic         dev_ack = 1'b0;
    logic [W-1:0] addr, data_out;
    logic [W-1:0] data_in = '0;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.WORD_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_ctrl  (m0_ctrl),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_stat  (m0_stat),
        .m1_ctrl  (m1_ctrl),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_stat  (m1_stat),
        .dev_ctrl (dev_ctrl),
        .dev_ack  (dev_ack),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called in an IDLE cycle with the request already driven (cycle 0).
    // Serves one read for master m, optionally re-raising its request.
    task automatic serve(input int m, input logic [W-1:0] exp_addr,
                         input logic [W-1:0] rd, input bit rereq);
        tick();                                   // cycle 1: ISSUE
        chk("srv_addr", addr, exp_addr);
        chk("srv_pin_c1", {30'd0, dev_ctrl}, 32'd0);
        tick();                                   // cycle 2: pin up
        chk("srv_pin_c2", {30'd0, dev_ctrl}, 32'd1);
        data_in = rd;
        dev_ack = 1'b1;
        tick();                                   // cycle 3: done
        chk("srv_pin_c3", {30'd0, dev_ctrl}, 32'd0);
        if (m == 0) begin
            chk("srv_m0_stat", {30'd0, m0_stat}, 32'd1);
            chk("srv_m1_idle", {30'd0, m1_stat}, 32'd0);
            chk("srv_m0_rdata", m0_rdata, rd);
            m0_ctrl = 2'b00;
        end else begin
            chk("srv_m1_stat", {30'd0, m1_stat}, 32'd1);
            chk("srv_m0_idle", {30'd0, m0_stat}, 32'd0);
            chk("srv_m1_rdata", m1_rdata, rd);
            m1_ctrl = 2'b00;
        end
        dev_ack = 1'b0;
        tick();                                   // cycle 4: IDLE, status clear
        chk("srv_clr_m0", {30'd0, m0_stat}, 32'd0);
        chk("srv_clr_m1", {30'd0, m1_stat}, 32'd0);
        if (rereq) begin
            if (m == 0) m0_ctrl = 2'b01;
            else        m1_ctrl = 2'b01;
        end
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_dev_ctrl", {30'd0, dev_ctrl}, 32'd0);
        chk("rst_m0_stat", {30'd0, m0_stat}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        do_reset();

        // Single read
        m0_ctrl = 2'b01;
        m0_addr = 32'h10;
        serve(0, 32'h10, 32'hCAFE, 1'b0);

        // Contention: both write from reset, m0 first
        do_reset();
        m0_ctrl = 2'b10; m0_addr = 32'h100; m0_wdata = 32'h11;
        m1_ctrl = 2'b10; m1_addr = 32'h200; m1_wdata = 32'h22;
        tick();                                   // c1
        chk("cont_dout0", data_out, 32'h11);
        chk("cont_addr0", addr, 32'h100);
        tick();                                   // c2
        chk("cont_pin0", {30'd0, dev_ctrl}, 32'd2);
        dev_ack = 1'b1;
        tick();                                   // c3
        chk("cont_m0_done", {30'd0, m0_stat}, 32'd1);
        chk("cont_m1_wait", {30'd0, m1_stat}, 32'd0);
        dev_ack = 1'b0;
        m0_ctrl = 2'b00;
        tick();                                   // c4 IDLE
        chk("cont_m0_clr", {30'd0, m0_stat}, 32'd0);
        tick();                                   // c5 new grant
        chk("cont_dout1", data_out, 32'h22);
        chk("cont_addr1", addr, 32'h200);
        tick();                                   // c6
        chk("cont_pin1", {30'd0, dev_ctrl}, 32'd2);
        chk("cont_m1_pend", {30'd0, m1_stat}, 32'd0);
        dev_ack = 1'b1;
        tick();                                   // c7
        chk("cont_m1_done", {30'd0, m1_stat}, 32'd1);
        chk("cont_m0_quiet", {30'd0, m0_stat}, 32'd0);
        chk("cont_m0_rd_keep", m0_rdata, 32'd0);
        dev_ack = 1'b0;
        m1_ctrl = 2'b00;
        tick();                                   // c8
        chk("cont_m1_clr", {30'd0, m1_stat}, 32'd0);

        // Fairness: m0 re-requests immediately, grants go m0, m1, m0
        m0_ctrl = 2'b01; m0_addr = 32'hA0;
        m1_ctrl = 2'b01; m1_addr = 32'hA1;
        serve(0, 32'hA0, 32'h1111, 1'b1);
        serve(1, 32'hA1, 32'h2222, 1'b0);
        serve(0, 32'hA0, 32'h3333, 1'b0);
        chk("fair_m1_rd_held", m1_rdata, 32'h2222);

        // Stuck ACK
        dev_ack = 1'b1;
        m0_ctrl = 2'b10; m0_addr = 32'hB0;
        tick();                                   // c1
        tick();                                   // c2
        chk("stuck_pin_c2", {30'd0, dev_ctrl}, 32'd0);
        tick();                                   // c3
        chk("stuck_pin_c3", {30'd0, dev_ctrl}, 32'd0);
        dev_ack = 1'b0;
        tick();                                   // c4
        chk("stuck_pin_rel", {30'd0, dev_ctrl}, 32'd2);
        dev_ack = 1'b1;
        tick();                                   // c5
        chk("stuck_done", {30'd0, m0_stat}, 32'd1);
        dev_ack = 1'b0;
        m0_ctrl = 2'b00;
        tick();

        // Timeout: ISSUE entered at c1, error visible at c1+TO+1
        m0_ctrl = 2'b01; m0_addr = 32'hC0;
        tick();                                   // c1
        for (int c = 2; c <= TO + 1; c++) begin
            tick();
            if (c == 2 || c == TO + 1) begin
                chk("to_pin_up", {30'd0, dev_ctrl}, 32'd1);
                chk("to_stat_low", {30'd0, m0_stat}, 32'd0);
            end
        end
        tick();                                   // c = TO+2
        chk("to_pin_drop", {30'd0, dev_ctrl}, 32'd0);
        chk("to_stat_err", {30'd0, m0_stat}, 32'd3);
        chk("to_rdata_keep", m0_rdata, 32'h3333);
        m0_ctrl = 2'b00;
        tick();
        chk("to_stat_clr", {30'd0, m0_stat}, 32'd0);

        // Illegal op on m1
        m1_ctrl = 2'b11; m1_addr = 32'hD0;
        tick();                                   // c1
        chk("ill_pin_c1", {30'd0, dev_ctrl}, 32'd0);
        tick();                                   // c2
        chk("ill_stat", {30'd0, m1_stat}, 32'd3);
        chk("ill_pin_c2", {30'd0, dev_ctrl}, 32'd0);
        chk("ill_m0_quiet", {30'd0, m0_stat}, 32'd0);
        m1_ctrl = 2'b00;
        tick();
        chk("ill_clr", {30'd0, m1_stat}, 32'd0);

        // Reset during WAIT
        m0_ctrl = 2'b01; m0_addr = 32'hE0;
        tick();                                   // c1
        tick();                                   // c2 WAIT, pin up
        chk("rw_pin_up", {30'd0, dev_ctrl}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_pin_zero", {30'd0, dev_ctrl}, 32'd0);
        chk("rw_m0_stat", {30'd0, m0_stat}, 32'd0);
        chk("rw_m1_stat", {30'd0, m1_stat}, 32'd0);
        chk("rw_addr", addr, 32'd0);
        m0_ctrl = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        chk("rw_idle_pin", {30'd0, dev_ctrl}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and sequencer for the shared motherboard device bus (`addr`, `data_out`, `data_in`, per-device read/write control pin, device ACK). Master 0 is the CPU path and master 1 is a secondary requester such as a DMA or VGA refresh engine. The block grants the bus round-robin and runs the device-side control/ACK handshake. It returns read data and a done/error status to the granted master using the same ctrl-held-until-done protocol the motherboard already uses.

## Interface
- `WORD_WIDTH`, 32: width of address and data.
- `TIMEOUT`, 255: maximum cycles spent in ISSUE+WAIT before the transfer is aborted with an error.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `m0_ctrl`, `m1_ctrl` in 2: request. Bit0 = read, bit1 = write, 0 = no request. Held stable until status done.
- `m0_addr`, `m1_addr` in WORD_WIDTH: request address.
- `m0_wdata`, `m1_wdata` in WORD_WIDTH: write data.
- `m0_rdata`, `m1_rdata` out WORD_WIDTH: read result. Held until that master's next completed read.
- `m0_stat`, `m1_stat` out 2: bit0 = done, bit1 = error.
- `dev_ctrl` out 2: bit0 = read pin, bit1 = write pin, to the addressed device.
- `dev_ack` in 1: device acknowledge.
- `addr` out WORD_WIDTH: device bus address.
- `data_out` out WORD_WIDTH: device bus write data.
- `data_in` in WORD_WIDTH: device bus read data.

## Operation

**Reset values.** All outputs are registered and reset to 0. State resets to IDLE, and the priority pointer resets to master 0.

**IDLE**
- Requests: master N requests when `mN_ctrl` ≠ 0.
- Arbitration: with one requester, it wins. With two, the master not served last wins.
- Capture: latch grant, `addr` ← `mN_addr`, `data_out` ← `mN_wdata`, op ← `mN_ctrl`, and clear the timeout counter.
- Illegal op: if op == 2'b11, go to DONE with error set and no bus cycle.
- Otherwise go to ISSUE.

**ISSUE**
- If `dev_ack` == 0, drive `dev_ctrl` ← op and go to WAIT.
- Otherwise stay. This waits for the previous device to release its ACK.

**WAIT**
- On `dev_ack` == 1:
  - read: `mN_rdata` ← `data_in`;
  - `dev_ctrl` ← 0;
  - go to DONE with error clear.

**Timeout**
- The counter increments every cycle in ISSUE and WAIT.
- When it reaches `TIMEOUT`: `dev_ctrl` ← 0, go to DONE with error set, and leave `rdata` untouched.

**DONE**
- `mN_stat` = {err, 1} for the granted master only. The other master's status stays 0.
- When `mN_ctrl` == 0: clear status, set the pointer to "N served last", and go to IDLE.

**General rules**
- The ungranted master's request waits with status 0. It is never dropped or starved: at most one transfer precedes it.
- `addr` and `data_out` hold their latched values from IDLE exit until the next grant.
- Reset mid-transfer: immediate abort, `dev_ctrl` = 0, no status is reported to either master.

## Timing
- Cycle 0: request visible in IDLE.
- Cycle 1: ISSUE (grant registered).
- Cycle 2: `dev_ctrl` asserted, given ACK low during ISSUE.
- ACK first sampled high at cycle k: `dev_ctrl` drops and `mN_stat` done is visible at k+1.
- Minimum transaction with ACK in the cycle after the pin: done at cycle 3.
- Master drops ctrl at cycle j: status clears and IDLE at j+1. A new grant is visible at j+2.
- Timeout error is visible `TIMEOUT`+1 cycles after entering ISSUE.
- Simultaneous requests at reset: master 0 first, then master 1.

## Structure
- Shared include with the control pin definitions holds:
  - CTRL_READ/CTRL_WRITE bit positions;
  - STAT_DONE/STAT_ERR bits;
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE.
- One sub-module, `arb_rr2`: a combinational two-requester round-robin picker (req[1:0], last → grant index, valid).
- The FSM, capture registers and timeout counter live in `bus_arbiter`.

## Test plan
- Single read: m0_ctrl=1, addr=0x10, device ACKs with data_in=0xCAFE one cycle after the pin → dev_ctrl=1 at cycle 2, m0_stat=1 at cycle 3, m0_rdata=0xCAFE. Drop ctrl → m0_stat=0 next cycle.
- Contention: both masters request write at reset, m0 data 0x11, m1 data 0x22 → data_out=0x11 first; after m0 done and cleared, data_out=0x22 to m1; m1_stat stays 0 until its own done.
- Fairness: m0 holds continuous back-to-back requests while m1 requests → grants alternate m0, m1, m0.
- Stuck ACK: dev_ack held 1 at request → dev_ctrl stays 0. Release ACK → pin asserts the following cycle.
- Timeout: TIMEOUT=8, device never ACKs → dev_ctrl drops and m0_stat=2'b11 nine cycles after ISSUE entry; m0_rdata unchanged.
- Illegal op and reset: m1_ctrl=3 → m1_stat=2'b11 at cycle 2, dev_ctrl never asserted. Assert rst during WAIT → dev_ctrl=0 and both statuses 0 immediately.
